// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with synchronous flush and an optional
// second (skid) entry so in_ready can come straight from a flop.
module pipe_stage_buf #(
  parameter int               WIDTH      = 32,
  parameter bit               SKID       = 1'b1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             drain;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  // With the skid entry present, in_ready depends only on the state flops.
  assign in_ready = SKID ? (state_q != FULL) : (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_DATA;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = MAIN;
          end
        end
        MAIN: begin
          // Without SKID, in_ready blocks the accept-without-drain case.
          if (accept && drain) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            main_d  = skid_q;
            state_d = MAIN;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  occupancyBound: assert property (@(posedge clk) disable iff (rst)
    occupancy <= (SKID ? 2'd2 : 2'd1));

  holdStable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule
